temporizador_bcd: RTL

TEMPORIZADOR_BCD -- requirements
Module: temporizador_bcd

---
 rtl/temporizador_bcd.sv | 109 ++++++++++
 1 files changed

// File: rtl/temporizador_bcd.sv
// BCD hh:mm:ss countdown timer with IDLE/RUN/PAUSE/DONE control and alarm flag.
// Latency: one clk from load/start/stop/tick to outputs; no backpressure, inputs always accepted.
module temporizador_bcd #(
    parameter logic [7:0] HORA_MAX = 8'h23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       load,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] hora_in,
    input  logic [7:0] minuto_in,
    input  logic [7:0] segundo_in,
    output logic [7:0] hora_out,
    output logic [7:0] minuto_out,
    output logic [7:0] segundo_out,
    output logic       corriendo,
    output logic       alarma
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t     state, state_nx;
    logic [7:0] hora_nx, minuto_nx, segundo_nx;
    logic [1:0] rst_sync;
    logic       rst_n;
    logic       count_zero, count_one;

    // Assertion is immediate; release is delayed by two edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    // A field with any non-decimal nibble is treated as out of range.
    function automatic logic [7:0] clamp_bcd(input logic [7:0] v, input logic [7:0] lim);
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v > lim) return lim;
        return v;
    endfunction

    function automatic logic [7:0] dec_bcd(input logic [7:0] v, input logic [7:0] wrap);
        if (v == 8'h00)        return wrap;
        if (v[3:0] == 4'd0)    return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    assign count_zero = (hora_out == 8'h00) && (minuto_out == 8'h00) && (segundo_out == 8'h00);
    assign count_one  = (hora_out == 8'h00) && (minuto_out == 8'h00) && (segundo_out == 8'h01);

    always_comb begin
        state_nx   = state;
        hora_nx    = hora_out;
        minuto_nx  = minuto_out;
        segundo_nx = segundo_out;
        if (load) begin
            state_nx   = IDLE;
            hora_nx    = clamp_bcd(hora_in, HORA_MAX);
            minuto_nx  = clamp_bcd(minuto_in, 8'h59);
            segundo_nx = clamp_bcd(segundo_in, 8'h59);
        end else begin
            case (state)
                IDLE, PAUSE: begin
                    if (start) state_nx = count_zero ? DONE : RUN;
                end
                RUN: begin
                    if (stop) begin
                        state_nx = PAUSE;
                    end else if (tick_1hz) begin
                        if (count_zero || count_one) begin
                            state_nx   = DONE;
                            hora_nx    = 8'h00;
                            minuto_nx  = 8'h00;
                            segundo_nx = 8'h00;
                        end else begin
                            segundo_nx = dec_bcd(segundo_out, 8'h59);
                            if (segundo_out == 8'h00) begin
                                minuto_nx = dec_bcd(minuto_out, 8'h59);
                                if (minuto_out == 8'h00) hora_nx = dec_bcd(hora_out, 8'h00);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Status flags are registered alongside the state so they track it exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            hora_out    <= 8'h00;
            minuto_out  <= 8'h00;
            segundo_out <= 8'h00;
            corriendo   <= 1'b0;
            alarma      <= 1'b0;
        end else begin
            state       <= state_nx;
            hora_out    <= hora_nx;
            minuto_out  <= minuto_nx;
            segundo_out <= segundo_nx;
            corriendo   <= (state_nx == RUN);
            alarma      <= (state_nx == DONE);
        end
    end

endmodule
